clb_config_loader: RTL and testbench
====================================

# clb_config_loader

Serial configuration loader for the CLB array. Receives a bitstream (preamble, length count, parity-protected frames, postamble) on a one-bit input. Assembles each frame into a 37-bit CLB configuration word and writes it to the addressed CLB with a one-cycle strobe. It writes the configuration fields that each CLB only reads: mux selects, LUT memory, combinational option, input-mux and DQ-mux selects, and the flop/latch bit.

## Interface
Parameters:
- NUM_CLB, 16, number of CLBs in the array; legal length counts are 1..NUM_CLB
- ADDR_W, 4, width of CFG_ADDR; must satisfy 2**ADDR_W >= NUM_CLB

Ports:
- K  input  1  clock; all state updates on its rising edge
- RST_N  input  1  asynchronous, active-low reset
- PROG  input  1  synchronous restart; returns to SYNC and clears DONE/ERR
- DIN  input  1  serial bitstream data
- DIN_VALID  input  1  DIN is sampled only on cycles where this is high
- CFG  output  37  assembled configuration word
- CFG_ADDR  output  ADDR_W  target CLB index
- CFG_WE  output  1  one-cycle write strobe
- BUSY  output  1  high from the first preamble bit until DONE or ERR
- DONE  output  1  sticky; load completed
- ERR  output  1  sticky; sync, length, parity or postamble error

## Operation
- CFG field layout, MSB first:
  - [36:35] mux2select, [34:33] mux3select, [32:31] mux4select, [30:29] mux5select, [28:27] mux6select
  - [26:11] LUT mem
  - [10:9] comboption
  - [8:3] o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1
  - [2:1] DQmux1, DQmux2
  - [0] floporlatch
- States: SYNC, LEN, FRAME, POST, DONE, ERROR. After reset or PROG the block is in SYNC.
- SYNC:
  - Shifts each valid bit into a 4-bit window.
  - When the window equals 0,0,1,0 (oldest first), moves to LEN.
  - Leading ones are idle and are ignored.
  - BUSY rises with the first valid 0 bit.
- LEN:
  - Takes 8 bits, MSB first.
  - A count of 0 or greater than NUM_CLB sends the block to ERROR.
  - Otherwise moves to FRAME with frame index 0.
- FRAME:
  - Takes 37 data bits, MSB first (first bit lands in CFG[36]), then 1 parity bit.
  - Parity is even over all 38 bits.
  - Parity good: CFG is loaded, CFG_ADDR is set to the frame index, CFG_WE pulses, and the index increments.
  - Parity bad: no strobe; moves to ERROR.
  - After the last frame, moves to POST.
- POST:
  - Takes 4 bits; all must be 1.
  - Any 0 sends the block to ERROR.
  - After the fourth 1, moves to DONE.
- DONE / ERROR:
  - Terminal states; DIN_VALID is ignored.
  - Exit only via PROG or RST_N.
  - BUSY is low in both.
- Bit and frame counters saturate. There is no wrap within a frame.
- The frame index never exceeds count-1.

## Timing
- Reset values: CFG=0, CFG_ADDR=0, CFG_WE=0, BUSY=0, DONE=0, ERR=0; state is SYNC.
- CFG_WE is high for exactly one cycle: the cycle after the edge that samples the parity bit. CFG and CFG_ADDR are valid in that cycle and hold their values until the next write.
- DONE rises one cycle after the edge that samples the 4th postamble bit.
- ERR rises one cycle after the offending bit.
- DIN_VALID may drop at any point. State is unchanged on invalid cycles, and there is no timeout.
- PROG and DIN_VALID in the same cycle: PROG wins and the bit is discarded.
- PROG while CFG_WE is high: the strobe still completes that cycle. The next cycle is SYNC with DONE=ERR=0.
- RST_N asserted mid-frame clears all state immediately. A partial frame never produces CFG_WE.
- Minimum load time for n frames: 4 + 8 + 38n + 4 valid cycles after the first preamble bit.

## Structure
- Package clb_cfg_pkg:
  - CFG field offsets and widths
  - FRAME_BITS = 37
  - PREAMBLE = 4'b0010
  - LEN_BITS = 8
  - POST_BITS = 4
  - state enum
- Sub-module clb_cfg_shift: 38-bit frame shift register with a running parity accumulator and a bit counter. It reports frame_full and parity_ok to the top-level FSM.

## Test plan
- Idle ones, then 0010, length 2, two valid frames (0x0_0000_0116 field-packed into mem, then all-ones), then 1111. Required: CFG_WE at addresses 0 and 1 with exact words, then DONE=1, ERR=0.
- Same stream with one data bit flipped in frame 1. Required: one CFG_WE (address 0) only, then ERR=1, DONE=0.
- Length byte 0 and length byte NUM_CLB+1. Required: ERR=1 one cycle after the 8th length bit, no CFG_WE.
- Valid stream with DIN_VALID low on random cycles. Required: identical writes and DONE, no extra strobes.
- RST_N pulsed low mid-frame, then a full valid stream. Required: all outputs zero during reset, no write from the partial frame, normal completion afterwards.
- PROG asserted in DONE and in ERROR, then postamble bits 1101. Required: flags cleared, second load ends with ERR=1.

Source files
------------

// File: rtl/clb_cfg_pkg.sv
// clb_cfg_pkg: shared constants, CFG field layout and loader state encoding
// for the CLB configuration loader.
package clb_cfg_pkg;
   localparam int FRAME_BITS = 37;
   localparam logic [3:0] PREAMBLE = 4'b0010;
   localparam int LEN_BITS = 8;
   localparam int POST_BITS = 4;
   localparam int MUX_LSB = 27;
   localparam int MUX_W = 10;
   localparam int LUT_LSB = 11;
   localparam int LUT_W = 16;
   localparam int COMB_LSB = 9;
   localparam int COMB_W = 2;
   localparam int O2M_LSB = 3;
   localparam int O2M_W = 6;
   localparam int DQ_LSB = 1;
   localparam int DQ_W = 2;
   localparam int FL_LSB = 0;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_LEN,
      ST_FRAME,
      ST_POST,
      ST_DONE,
      ST_ERROR
   } state_e;

   function automatic logic [FRAME_BITS-1:0] pack_cfg(
      input logic [MUX_W-1:0] mux,
      input logic [LUT_W-1:0] lut,
      input logic [COMB_W-1:0] comb,
      input logic [O2M_W-1:0] o2m,
      input logic [DQ_W-1:0] dq,
      input logic fl
   );
      logic [FRAME_BITS-1:0] w;
      w = '0;
      w[MUX_LSB +: MUX_W] = mux;
      w[LUT_LSB +: LUT_W] = lut;
      w[COMB_LSB +: COMB_W] = comb;
      w[O2M_LSB +: O2M_W] = o2m;
      w[DQ_LSB +: DQ_W] = dq;
      w[FL_LSB] = fl;
      return w;
   endfunction
endpackage

// File: rtl/clb_config_loader_if.sv
// clb_config_loader_if: serial bitstream input and CLB write port of the loader.
interface clb_config_loader_if #(parameter int ADDR_W = 4) ();
   logic PROG;
   logic DIN;
   logic DIN_VALID;
   logic [36:0] CFG;
   logic [ADDR_W-1:0] CFG_ADDR;
   logic CFG_WE;
   logic BUSY;
   logic DONE;
   logic ERR;

   modport master (
      output PROG, DIN, DIN_VALID,
      input CFG, CFG_ADDR, CFG_WE, BUSY, DONE, ERR
   );

   modport slave (
      input PROG, DIN, DIN_VALID,
      output CFG, CFG_ADDR, CFG_WE, BUSY, DONE, ERR
   );
endinterface

// File: rtl/clb_cfg_shift.sv
// clb_cfg_shift: frame shift register with running parity and bit counter;
// flags the parity bit of each frame and whether even parity held.
module clb_cfg_shift
   import clb_cfg_pkg::*;
(
   input  logic K,
   input  logic RST_N,
   input  logic clr,
   input  logic en,
   input  logic din,
   output logic [FRAME_BITS-1:0] data,
   output logic frame_full,
   output logic parity_ok
);
   logic [FRAME_BITS-1:0] sr_q, sr_d;
   logic [5:0] cnt_q, cnt_d;
   logic par_q, par_d;

   // the 38th bit is parity and is never shifted in; data holds the 37 payload bits
   assign frame_full = en && cnt_q == 6'(FRAME_BITS);
   assign parity_ok = ~(par_q ^ din);
   assign data = sr_q;

   always_comb begin
      sr_d = sr_q;
      cnt_d = cnt_q;
      par_d = par_q;
      if (clr || frame_full) begin
         cnt_d = '0;
         par_d = 1'b0;
      end else if (en) begin
         sr_d = {sr_q[FRAME_BITS-2:0], din};
         cnt_d = cnt_q + 6'd1;
         par_d = par_q ^ din;
      end
   end

   always_ff @(posedge K or negedge RST_N) begin
      if (!RST_N) begin
         sr_q <= '0;
         cnt_q <= '0;
         par_q <= 1'b0;
      end else begin
         sr_q <= sr_d;
         cnt_q <= cnt_d;
         par_q <= par_d;
      end
   end
endmodule

// File: rtl/clb_config_loader.sv
// clb_config_loader: parses preamble, length, parity-protected frames and
// postamble from a serial stream and writes each frame to its CLB.
module clb_config_loader
   import clb_cfg_pkg::*;
#(
   parameter int NUM_CLB = 16,
   parameter int ADDR_W = 4
) (
   input logic K,
   input logic RST_N,
   clb_config_loader_if.slave bus
);
   state_e state_q, state_d;
   logic [3:0] win_q, win_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] len_q, len_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [FRAME_BITS-1:0] cfg_q, cfg_d;
   logic we_q, we_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic err_q, err_d;
   logic v;
   logic sh_clr;
   logic sh_en;
   logic [FRAME_BITS-1:0] sh_data;
   logic frame_full;
   logic parity_ok;

   // PROG beats a coincident valid bit, which is then dropped
   assign v = bus.DIN_VALID && !bus.PROG;
   assign sh_en = v && state_q == ST_FRAME;
   assign sh_clr = bus.PROG || state_q != ST_FRAME;

   clb_cfg_shift u_shift (
      .K(K),
      .RST_N(RST_N),
      .clr(sh_clr),
      .en(sh_en),
      .din(bus.DIN),
      .data(sh_data),
      .frame_full(frame_full),
      .parity_ok(parity_ok)
   );

   always_comb begin
      state_d = state_q;
      win_d = win_q;
      cnt_d = cnt_q;
      len_d = len_q;
      idx_d = idx_q;
      addr_d = addr_q;
      cfg_d = cfg_q;
      we_d = 1'b0;
      busy_d = busy_q;
      done_d = done_q;
      err_d = err_q;
      if (bus.PROG) begin
         state_d = ST_SYNC;
         win_d = 4'hF;
         cnt_d = '0;
         busy_d = 1'b0;
         done_d = 1'b0;
         err_d = 1'b0;
      end else if (v) begin
         case (state_q)
            ST_SYNC: begin
               win_d = {win_q[2:0], bus.DIN};
               busy_d = busy_q | ~bus.DIN;
               if (win_d == PREAMBLE) begin
                  state_d = ST_LEN;
                  cnt_d = '0;
               end
            end
            ST_LEN: begin
               len_d = {len_q[6:0], bus.DIN};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'(LEN_BITS - 1)) begin
                  cnt_d = '0;
                  idx_d = '0;
                  state_d = (len_d == 8'd0 || len_d > 8'(NUM_CLB)) ? ST_ERROR : ST_FRAME;
               end
            end
            ST_FRAME: begin
               if (frame_full && parity_ok) begin
                  cfg_d = sh_data;
                  addr_d = idx_q;
                  we_d = 1'b1;
                  if (8'(idx_q) == len_q - 8'd1) begin
                     state_d = ST_POST;
                     cnt_d = '0;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else if (frame_full) begin
                  state_d = ST_ERROR;
               end
            end
            ST_POST: begin
               cnt_d = cnt_q + 3'd1;
               if (!bus.DIN) begin
                  state_d = ST_ERROR;
               end else if (cnt_q == 3'(POST_BITS - 1)) begin
                  state_d = ST_DONE;
               end
            end
            default: ;
         endcase
         if (state_d == ST_ERROR && state_q != ST_ERROR) begin
            err_d = 1'b1;
            busy_d = 1'b0;
         end
         if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge K or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_SYNC;
         win_q <= 4'hF;
         cnt_q <= '0;
         len_q <= '0;
         idx_q <= '0;
         addr_q <= '0;
         cfg_q <= '0;
         we_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q <= win_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
         idx_q <= idx_d;
         addr_q <= addr_d;
         cfg_q <= cfg_d;
         we_q <= we_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q <= err_d;
      end
   end

   assign bus.CFG = cfg_q;
   assign bus.CFG_ADDR = addr_q;
   assign bus.CFG_WE = we_q;
   assign bus.BUSY = busy_q;
   assign bus.DONE = done_q;
   assign bus.ERR = err_q;
endmodule

// File: tb/tb_clb_config_loader.sv
// tb_clb_config_loader: randomized bitstreams checked against a stream-level
// model of which frames get written and how each load terminates.
module tb_clb_config_loader;
   import clb_cfg_pkg::*;
   localparam int NUM_CLB = 16;
   localparam int ADDR_W = 4;

   logic K = 1'b0;
   logic RST_N = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   int gap_pct = 0;
   logic [ADDR_W+36:0] wq[$];
   logic [36:0] frames[NUM_CLB];

   clb_config_loader_if #(.ADDR_W(ADDR_W)) bus ();

   clb_config_loader #(.NUM_CLB(NUM_CLB), .ADDR_W(ADDR_W)) dut (
      .K(K),
      .RST_N(RST_N),
      .bus(bus.slave)
   );

   always #5 K = ~K;

   always @(negedge K) if (bus.CFG_WE === 1'b1) wq.push_back({bus.CFG_ADDR, bus.CFG});

   task automatic send_bit(input logic b);
      while ($urandom_range(99) < gap_pct) begin
         bus.DIN_VALID = 1'b0;
         bus.DIN = 1'($urandom);
         @(posedge K);
         #1;
      end
      bus.DIN = b;
      bus.DIN_VALID = 1'b1;
      @(posedge K);
      #1;
      bus.DIN_VALID = 1'b0;
   endtask

   task automatic send_bits(input logic [63:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
   endtask

   task automatic prog_pulse();
      bus.PROG = 1'b1;
      @(posedge K);
      #1;
      bus.PROG = 1'b0;
   endtask

   // idle ones, preamble, length and frames; frame `bad` gets one flipped data bit
   task automatic send_body(input int len, input int bad);
      logic [36:0] d;
      logic p;
      send_bits(64'h7, 3);
      send_bits(64'(PREAMBLE), 4);
      send_bits(64'(len), 8);
      if (len >= 1 && len <= NUM_CLB) begin
         for (int f = 0; f < len; f++) begin
            d = frames[f];
            p = ^frames[f];
            if (f == bad) d[$urandom_range(36)] ^= 1'b1;
            send_bits(64'(d), 37);
            send_bit(p);
            n_cmp++;
            if (bus.CFG_WE !== (f < bad)) begin
               n_bad++;
               $display("FAIL we_after_parity f=%0d: got %b want %b", f, bus.CFG_WE, (f < bad));
            end
         end
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({bus.CFG, bus.CFG_ADDR, bus.CFG_WE, bus.BUSY, bus.DONE, bus.ERR} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 0", {bus.CFG, bus.CFG_ADDR, bus.CFG_WE, bus.BUSY, bus.DONE, bus.ERR});
      end
      repeat (3) @(posedge K);
      #1;
      RST_N = 1'b1;
      send_bits(64'hFF, 6);
      n_cmp++;
      if ({bus.BUSY, bus.DONE, bus.ERR} !== 3'b000) begin
         n_bad++;
         $display("FAIL idle_ones: got %b want 000", {bus.BUSY, bus.DONE, bus.ERR});
      end
      send_bit(1'b0);
      n_cmp++;
      if (bus.BUSY !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_first_zero: got %b want 1", bus.BUSY);
      end
      prog_pulse();
   endtask

   task automatic test_basic();
      int nw;
      frames[0] = pack_cfg('0, 16'h0116, '0, '0, '0, 1'b0);
      frames[1] = '1;
      gap_pct = 0;
      wq.delete();
      send_body(2, 99);
      send_bits(64'h7, 3);
      n_cmp++;
      if ({bus.DONE, bus.BUSY} !== 2'b01) begin
         n_bad++;
         $display("FAIL done_early: got %b want 01", {bus.DONE, bus.BUSY});
      end
      send_bit(1'b1);
      n_cmp++;
      if ({bus.DONE, bus.ERR, bus.BUSY} !== 3'b100) begin
         n_bad++;
         $display("FAIL basic_flags: got %b want 100", {bus.DONE, bus.ERR, bus.BUSY});
      end
      @(negedge K);
      nw = 2;
      n_cmp++;
      if (wq.size() !== nw) begin
         n_bad++;
         $display("FAIL basic_writes: got %0d want %0d", wq.size(), nw);
      end
      for (int i = 0; i < nw && i < wq.size(); i++) begin
         n_cmp++;
         if (wq[i] !== {ADDR_W'(i), frames[i]}) begin
            n_bad++;
            $display("FAIL basic_word%0d: got %h want %h", i, wq[i], {ADDR_W'(i), frames[i]});
         end
      end
      prog_pulse();
   endtask

   task automatic test_parity_err();
      wq.delete();
      send_body(2, 1);
      send_bits(64'hF, 4);
      @(negedge K);
      n_cmp++;
      if (wq.size() !== 1) begin
         n_bad++;
         $display("FAIL parity_writes: got %0d want 1", wq.size());
      end else begin
         n_cmp++;
         if (wq[0] !== {ADDR_W'(0), frames[0]}) begin
            n_bad++;
            $display("FAIL parity_word0: got %h want %h", wq[0], {ADDR_W'(0), frames[0]});
         end
      end
      n_cmp++;
      if ({bus.DONE, bus.ERR, bus.BUSY} !== 3'b010) begin
         n_bad++;
         $display("FAIL parity_flags: got %b want 010", {bus.DONE, bus.ERR, bus.BUSY});
      end
      prog_pulse();
   endtask

   task automatic test_bad_len();
      logic [7:0] lens[2];
      lens[0] = 8'd0;
      lens[1] = 8'(NUM_CLB + 1);
      foreach (lens[k]) begin
         wq.delete();
         send_bits(64'h7, 3);
         send_bits(64'(PREAMBLE), 4);
         send_bits(64'(lens[k] >> 1), 7);
         n_cmp++;
         if ({bus.ERR, bus.BUSY} !== 2'b01) begin
            n_bad++;
            $display("FAIL len%0d_pre: got %b want 01", lens[k], {bus.ERR, bus.BUSY});
         end
         send_bit(lens[k][0]);
         n_cmp++;
         if ({bus.ERR, bus.BUSY, bus.DONE} !== 3'b100) begin
            n_bad++;
            $display("FAIL len%0d_err: got %b want 100", lens[k], {bus.ERR, bus.BUSY, bus.DONE});
         end
         send_bits(64'h0123456789, 40);
         n_cmp++;
         if (wq.size() !== 0) begin
            n_bad++;
            $display("FAIL len%0d_writes: got %0d want 0", lens[k], wq.size());
         end
         prog_pulse();
      end
   endtask

   task automatic test_gaps_and_random();
      int len, bad, nw;
      logic [3:0] post;
      logic done, err;
      for (int it = 0; it < 5; it++) begin
         gap_pct = (it == 0) ? 40 : 20;
         len = (it == 0) ? 2 : $urandom_range(1, 8);
         bad = (it == 0) ? 99 : $urandom_range(0, len + 2);
         post = (it == 0 || $urandom_range(1)) ? 4'hF : 4'($urandom_range(14));
         if (it == 0) begin
            frames[0] = pack_cfg('0, 16'h0116, '0, '0, '0, 1'b0);
            frames[1] = '1;
         end else begin
            for (int i = 0; i < len; i++) frames[i] = 37'({$urandom, $urandom});
         end
         nw = (bad < len) ? bad : len;
         err = bad < len || post != 4'hF;
         done = !err;
         wq.delete();
         send_body(len, bad);
         send_bits(64'(post), 4);
         @(negedge K);
         n_cmp++;
         if (wq.size() !== nw) begin
            n_bad++;
            $display("FAIL rnd%0d_writes: got %0d want %0d", it, wq.size(), nw);
         end
         for (int i = 0; i < nw && i < wq.size(); i++) begin
            n_cmp++;
            if (wq[i] !== {ADDR_W'(i), frames[i]}) begin
               n_bad++;
               $display("FAIL rnd%0d_word%0d: got %h want %h", it, i, wq[i], {ADDR_W'(i), frames[i]});
            end
         end
         n_cmp++;
         if ({bus.DONE, bus.ERR, bus.BUSY} !== {done, err, 1'b0}) begin
            n_bad++;
            $display("FAIL rnd%0d_flags: got %b want %b", it, {bus.DONE, bus.ERR, bus.BUSY}, {done, err, 1'b0});
         end
         prog_pulse();
      end
      gap_pct = 0;
   endtask

   task automatic test_reset_mid();
      frames[0] = 37'h15_5555_5555;
      frames[1] = 37'h0A_AAAA_AAAA;
      frames[2] = 37'h1F_0F0F_0F0F;
      wq.delete();
      send_bits(64'h7, 3);
      send_bits(64'(PREAMBLE), 4);
      send_bits(64'd3, 8);
      send_bits(64'(frames[0] >> 17), 20);
      RST_N = 1'b0;
      #1;
      n_cmp++;
      if ({bus.CFG, bus.CFG_ADDR, bus.CFG_WE, bus.BUSY, bus.DONE, bus.ERR} !== '0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got %h want 0", {bus.CFG, bus.CFG_ADDR, bus.CFG_WE, bus.BUSY, bus.DONE, bus.ERR});
      end
      repeat (2) @(posedge K);
      #1;
      RST_N = 1'b1;
      send_bits(64'(frames[0]), 18);
      n_cmp++;
      if (wq.size() !== 0) begin
         n_bad++;
         $display("FAIL midreset_partial: got %0d writes want 0", wq.size());
      end
      send_body(3, 99);
      send_bits(64'hF, 4);
      @(negedge K);
      n_cmp++;
      if (wq.size() !== 3) begin
         n_bad++;
         $display("FAIL midreset_writes: got %0d want 3", wq.size());
      end
      for (int i = 0; i < 3 && i < wq.size(); i++) begin
         n_cmp++;
         if (wq[i] !== {ADDR_W'(i), frames[i]}) begin
            n_bad++;
            $display("FAIL midreset_word%0d: got %h want %h", i, wq[i], {ADDR_W'(i), frames[i]});
         end
      end
      n_cmp++;
      if ({bus.DONE, bus.ERR} !== 2'b10) begin
         n_bad++;
         $display("FAIL midreset_flags: got %b want 10", {bus.DONE, bus.ERR});
      end
   endtask

   task automatic test_prog();
      bus.DIN = 1'b0;
      bus.DIN_VALID = 1'b1;
      prog_pulse();
      n_cmp++;
      if ({bus.DONE, bus.ERR, bus.BUSY} !== 3'b000) begin
         n_bad++;
         $display("FAIL prog_from_done: got %b want 000", {bus.DONE, bus.ERR, bus.BUSY});
      end
      wq.delete();
      send_body(2, 99);
      send_bits(64'hD, 4);
      @(negedge K);
      n_cmp++;
      if ({wq.size() == 2, bus.DONE, bus.ERR} !== 3'b101) begin
         n_bad++;
         $display("FAIL post_1101: got writes=%0d done=%b err=%b want writes=2 done=0 err=1", wq.size(), bus.DONE, bus.ERR);
      end
      prog_pulse();
      n_cmp++;
      if ({bus.DONE, bus.ERR, bus.BUSY} !== 3'b000) begin
         n_bad++;
         $display("FAIL prog_from_err: got %b want 000", {bus.DONE, bus.ERR, bus.BUSY});
      end
      wq.delete();
      send_bits(64'h7, 3);
      send_bits(64'(PREAMBLE), 4);
      send_bits(64'd2, 8);
      send_bits(64'(frames[0]), 37);
      send_bit(^frames[0]);
      bus.PROG = 1'b1;
      @(posedge K);
      #1;
      bus.PROG = 1'b0;
      n_cmp++;
      if ({wq.size() == 1, bus.CFG_WE, bus.BUSY, bus.DONE, bus.ERR} !== 5'b10000) begin
         n_bad++;
         $display("FAIL prog_during_we: got writes=%0d we=%b busy=%b done=%b err=%b want 1 0 0 0 0", wq.size(), bus.CFG_WE, bus.BUSY, bus.DONE, bus.ERR);
      end
   endtask

   initial begin
      bus.PROG = 1'b0;
      bus.DIN = 1'b1;
      bus.DIN_VALID = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_parity_err();
      test_bad_len();
      test_gaps_and_random();
      test_reset_mid();
      test_prog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
